// File: rtl/hilo_write_unit.sv
// HI/LO special-register write unit: multiply, restoring divide, MTHI/MTLO.
// Owns architectural HI/LO; busy stalls the core during a divide.
module hilo_write_unit #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic        r_qneg;
   logic        r_rneg;
   logic        r_dz;

   logic        w_sgn;
   logic        w_div;
   logic        w_last;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [32:0] w_sh;
   logic        w_ge;
   logic [31:0] w_sub;
   logic [31:0] w_rem_nx;
   logic [31:0] w_q_fix;
   logic [31:0] w_r_fix;

   assign w_sgn  = (op == OP_DIV);
   assign w_div  = start && (r_state == S_IDLE)
                   && (op == OP_DIV || op == OP_DIVU);
   assign w_last = (r_cnt == 5'(DIV_ITERS - 1));

   // Both operands widened to 64 bits so one unsigned multiply covers MULT.
   assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign w_prod_u = {32'b0, rs_val} * {32'b0, rt_val};

   assign w_a_mag = (w_sgn && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
   assign w_b_mag = (w_sgn && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;

   // 33-bit compare keeps divisors >= 2^31 correct; the difference fits 32 bits.
   assign w_sh     = {r_rem, r_quo[31]};
   assign w_ge     = (w_sh >= {1'b0, r_dvs});
   assign w_sub    = w_sh[31:0] - r_dvs;
   assign w_rem_nx = w_ge ? w_sub : w_sh[31:0];

   assign w_q_fix = r_dz   ? 32'hFFFF_FFFF :
                    r_qneg ? (~r_quo + 32'd1) : r_quo;
   assign w_r_fix = r_rneg ? (~r_rem + 32'd1) : r_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_div) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
         r_dz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: if (start) begin
               case (op)
                  OP_MULT: begin
                     {r_hi, r_lo} <= w_prod_s;
                     r_done       <= 1'b1;
                  end
                  OP_MULTU: begin
                     {r_hi, r_lo} <= w_prod_u;
                     r_done       <= 1'b1;
                  end
                  OP_MTHI: begin
                     r_hi   <= rs_val;
                     r_done <= 1'b1;
                  end
                  OP_MTLO: begin
                     r_lo   <= rs_val;
                     r_done <= 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     r_quo  <= w_a_mag;
                     r_dvs  <= w_b_mag;
                     r_rem  <= '0;
                     r_qneg <= w_sgn && (rs_val[31] ^ rt_val[31]);
                     r_rneg <= w_sgn && rs_val[31];
                     r_dz   <= (rt_val == 32'd0);
                     r_cnt  <= '0;
                  end
                  default: ;
               endcase
            end
            S_RUN: begin
               r_rem <= w_rem_nx;
               r_quo <= {r_quo[30:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               r_lo   <= w_q_fix;
               r_hi   <= w_r_fix;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_done;
   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_hilo_write_unit.sv
// Directed-vector bench for hilo_write_unit.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_hilo_write_unit;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_NONE7 = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   hilo_write_unit #(.DIV_ITERS(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .hi     (hi),
      .lo     (lo),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tg, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tg, got, exp);
      end
   endtask

   // Issue one command; returns 1ns after its accept edge.
   task automatic cmd(input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op     = OP_NONE;
      rs_val = $urandom;
      rt_val = $urandom;
   endtask

   task automatic run_div(input string tg, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
      int nb;
      cmd(o, a, b);
      nb = 0;
      while (busy && nb < 100) begin
         nb++;
         @(posedge clk);
         #1;
      end
      chk({tg, "_busy_cycles"}, 64'(nb), 64'd33);
      chk({tg, "_done"}, {63'b0, done}, 64'd1);
      chk({tg, "_hi"}, {32'b0, hi}, {32'b0, ehi});
      chk({tg, "_lo"}, {32'b0, lo}, {32'b0, elo});
      @(posedge clk);
      #1;
      chk({tg, "_done_drop"}, {63'b0, done}, 64'd0);
   endtask

   initial begin
      int nd;
      rst    = 1'b1;
      start  = 1'b0;
      op     = OP_NONE;
      rs_val = '0;
      rt_val = '0;
      #2;
      chk("rst_hi", {32'b0, hi}, 64'd0);
      chk("rst_lo", {32'b0, lo}, 64'd0);
      chk("rst_busy_done", {62'b0, busy, done}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Preload so the mid-divide reset has something to clear
      cmd(OP_MTHI, 32'hAAAA_5555, 32'h0);
      chk("mthi_hi", {32'b0, hi}, 64'hAAAA_5555);
      chk("mthi_done", {63'b0, done}, 64'd1);
      cmd(OP_MTLO, 32'h1357_9BDF, 32'h0);
      chk("mtlo_lo", {32'b0, lo}, 64'h1357_9BDF);
      chk("mtlo_hi_kept", {32'b0, hi}, 64'hAAAA_5555);

      cmd(OP_DIVU, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      chk("midrst_busy_before", {63'b0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      chk("midrst_hi", {32'b0, hi}, 64'd0);
      chk("midrst_lo", {32'b0, lo}, 64'd0);
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      cmd(OP_MTLO, 32'd5, 32'd0);
      nd = done ? 1 : 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      chk("postrst_lo", {32'b0, lo}, 64'd5);
      chk("postrst_hi", {32'b0, hi}, 64'd0);
      chk("postrst_done_cnt", 64'(nd), 64'd1);

      cmd(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      chk("mult_done", {63'b0, done}, 64'd1);
      chk("mult_busy", {63'b0, busy}, 64'd0);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      @(posedge clk);
      #1;
      chk("mult_done_drop", {62'b0, busy, done}, 64'd0);
      cmd(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      chk("multu_done", {62'b0, busy, done}, 64'd1);
      chk("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

      cmd(OP_NONE, 32'h1111_1111, 32'h2);
      chk("nop0_done", {62'b0, busy, done}, 64'd0);
      chk("nop0_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
      cmd(OP_NONE7, 32'h2222_2222, 32'h2);
      chk("nop7_done", {62'b0, busy, done}, 64'd0);
      chk("nop7_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

      run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD);
      run_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001,
              32'h7FFF_FFFE, 32'd1);
      run_div("divu_by0", OP_DIVU, 32'd9, 32'd0,
              32'd9, 32'hFFFF_FFFF);
      run_div("div_neg_by0", OP_DIV, 32'hFFFF_FFF7, 32'd0,
              32'hFFFF_FFF7, 32'hFFFF_FFFF);
      run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000);
      run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

      // MTHI issued while the divide is running must be dropped
      cmd(OP_DIV, 32'd100, 32'd7);
      nd = done ? 1 : 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            @(negedge clk);
            start  = 1'b1;
            op     = OP_MTHI;
            rs_val = 32'h1234;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         op    = OP_NONE;
         if (done) nd++;
      end
      chk("rej_done_cnt", 64'(nd), 64'd1);
      chk("rej_hi", {32'b0, hi}, 64'd2);
      chk("rej_lo", {32'b0, lo}, 64'd14);

      @(negedge clk);
      start  = 1'b1;
      op     = OP_MTHI;
      rs_val = 32'hCAFE_0001;
      @(posedge clk);
      #1;
      chk("b2b_hi1", {hi, lo}, {32'hCAFE_0001, 32'd14});
      chk("b2b_done1", {63'b0, done}, 64'd1);
      @(negedge clk);
      op     = OP_MTLO;
      rs_val = 32'hBEEF_0002;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = OP_NONE;
      chk("b2b_lo2", {hi, lo}, {32'hCAFE_0001, 32'hBEEF_0002});
      chk("b2b_done2", {63'b0, done}, 64'd1);
      @(posedge clk);
      #1;
      chk("b2b_hold", {hi, lo}, {32'hCAFE_0001, 32'hBEEF_0002});
      chk("b2b_done_drop", {63'b0, done}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_write_unit.md
Name: hilo_write_unit

Overview:
- Write side of the HI/LO special-register pair in the 54-instruction MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI and LO registers.
- The EX-stage read mux takes the hi/lo outputs for MFHI/MFLO.
- busy stalls the pipeline during an iterative divide.

Parameters:
- DIV_ITERS, 32: number of restoring-division iterations. Equals the operand width and must not be changed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled on a rising edge of clk
- op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
- rs_val  input  32  rs operand: dividend, multiplicand, or MTHI/MTLO source
- rt_val  input  32  rt operand: divisor or multiplier
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register
- busy  output  1  divide in progress; the core must stall HI/LO users and new commands
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new value

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. While rst=1: hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0. Reset during a divide aborts it; no partial result is ever written.
- FSM states: IDLE, DIV_RUN, DIV_FIX.
- Command acceptance: only in IDLE with start=1. op 000/111 is a no-op (no done). start while busy=1 is ignored and does not queue.
- MULT/MULTU: the 64-bit product of rs_val*rt_val (signed / unsigned) is registered at the accept edge. {hi,lo}=product, done=1 in the following cycle. busy stays 0.
- MTHI/MTLO: hi (or lo) loads rs_val at the accept edge; the other register is unchanged. done=1 in the following cycle.
- DIV/DIVU, accept edge:
  - latch operand magnitudes (absolute values for DIV) and the result signs;
  - clear the 32-bit partial remainder;
  - FSM→DIV_RUN, busy=1, counter=0.
- DIV_RUN: one restoring step per edge.
  - Shift the remainder left, bringing in the dividend MSB.
  - If remainder ≥ divisor: subtract it and set quotient bit=1.
  - Use a 33-bit compare so divisors ≥ 2^31 (DIVU) are handled.
  - After DIV_ITERS steps (counter=31 → wrap), FSM→DIV_FIX.
- DIV_FIX: apply signs (DIV only).
  - Quotient is negative if the operand signs differ; it truncates toward zero.
  - Remainder takes the dividend's sign.
  - Write lo=quotient, hi=remainder, busy←0, FSM→IDLE; done=1 in the next cycle.
- DIV latency: accept edge E0, iterations E1..E32, write at E33. busy=1 for exactly 33 cycles.
- Divide by zero (rt_val=0, DIV or DIVU): full latency still applies. lo=32'hFFFF_FFFF, hi=rs_val.
- Signed overflow (DIV, 0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0.
- Operand stability: rs_val/rt_val may change after the accept edge; all arithmetic uses latched copies.
- hi/lo hold their value at all times except the documented write edges. No output is combinational from inputs.

Test Plan:
- Reset mid-operation: DIVU 100/7, assert rst at cycle 10 → hi=0, lo=0, busy=0 immediately; then MTLO 5 → lo=5, done pulses once.
- MULT vs MULTU: MULT rs=0xFFFF_FFFE (−2), rt=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, done one cycle after accept, busy never 1. MULTU, same operands → hi=0x2, lo=0xFFFF_FFFA.
- Signed DIV: DIV −7/2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). busy high exactly 33 cycles, done in cycle 34. DIV 7/−2 → lo=−3, hi=1.
- DIVU large divisor: DIVU 0xFFFF_FFFF / 0x8000_0001 → lo=1, hi=0x7FFF_FFFE.
- Corner divides: DIVU 9/0 → lo=0xFFFF_FFFF, hi=9. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Busy rejection: during a DIV, start MTHI 0x1234 at cycle 5 → ignored, hi equals the division remainder afterwards, exactly one done pulse. MTHI/MTLO back-to-back → each register updates, the other is preserved.
